// File: rtl/matriz_alu_pkg.sv
// Shared opcodes, FSM state encoding and element-index helper for the sequential matrix ALU.
package matriz_alu_pkg;

    localparam logic [3:0] OP_SOMA   = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b0100;
    localparam logic [3:0] OP_MUL    = 4'b0101;
    localparam logic [3:0] OP_TRANSP = 4'b0110;
    localparam logic [3:0] OP_OPOSTA = 4'b0111;
    localparam logic [3:0] OP_ESC    = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flat element index of (row i, column j) in a dim x dim bus.
    function automatic int unsigned elem_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned dim);
        return i * dim + j;
    endfunction

    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_SOMA, OP_SUB, OP_MUL, OP_TRANSP, OP_OPOSTA, OP_ESC: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/matriz_alu_seq_sat.sv
// Reduces a signed full-precision value to DATA_W bits by saturation or wrap, flagging overflow.
module mat_elem_sat #(
    parameter int unsigned IN_W     = 17,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic signed [IN_W-1:0]   val_i,
    output logic        [DATA_W-1:0] res_o,
    output logic                     ovf_o
);

    logic fits;

    always_comb begin
        // Value is representable iff all bits above the target sign bit copy it.
        fits  = (val_i[IN_W-1:DATA_W-1] == {(IN_W-DATA_W+1){val_i[DATA_W-1]}});
        ovf_o = ~fits;
        res_o = val_i[DATA_W-1:0];
        if (SATURATE != 0 && !fits) begin
            res_o = val_i[IN_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/matriz_alu_seq.sv
// Sequential matrix ALU: one row per cycle for element-wise ops, one element per cycle for A*B.
module matriz_alu_seq
    import matriz_alu_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N        = 5,
    parameter int unsigned SATURATE = 1,
    parameter int unsigned SIZE_W   = $clog2(N+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [SIZE_W-1:0]       tamanho,
    input  logic [DATA_W-1:0]       data_escalar,
    input  logic [N*N*DATA_W-1:0]   matriz_a,
    input  logic [N*N*DATA_W-1:0]   matriz_b,
    output logic [N*N*DATA_W-1:0]   matriz_resultante,
    output logic                    done,
    output logic                    busy,
    output logic                    overflow,
    output logic                    err
);

    localparam int unsigned MAT_W = N * N * DATA_W;
    localparam int unsigned ROW_W = 2 * DATA_W;
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N);

    state_e                    state_q;
    logic [3:0]                op_q;
    logic [SIZE_W-1:0]         n_q, r_q, c_q;
    logic signed [DATA_W-1:0]  esc_q;
    logic [MAT_W-1:0]          a_q, b_q, buf_q, buf_d, res_q;
    logic                      done_q, busy_q, ovf_q, err_q;

    logic signed [ROW_W-1:0]   row_full [N];
    logic [DATA_W-1:0]         row_res  [N];
    logic [N-1:0]              row_ovf;
    logic signed [ACC_W-1:0]   acc, pa, pb;
    logic [DATA_W-1:0]         mac_res;
    logic                      mac_ovf, ovf_step, last, start_ok;
    logic signed [ROW_W-1:0]   xa, xb, xe;
    int unsigned               ri, ci, nn;

    function automatic logic signed [DATA_W-1:0] elem(input logic [MAT_W-1:0] m,
                                                      input int unsigned i,
                                                      input int unsigned j);
        return m[elem_idx(i, j, N)*DATA_W +: DATA_W];
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_row
        mat_elem_sat #(.IN_W(ROW_W), .DATA_W(DATA_W), .SATURATE(SATURATE)) u_sat (
            .val_i (row_full[g]),
            .res_o (row_res[g]),
            .ovf_o (row_ovf[g])
        );
    end

    mat_elem_sat #(.IN_W(ACC_W), .DATA_W(DATA_W), .SATURATE(SATURATE)) u_mac_sat (
        .val_i (acc),
        .res_o (mac_res),
        .ovf_o (mac_ovf)
    );

    always_comb begin
        ri = 32'(r_q);
        ci = 32'(c_q);
        nn = 32'(n_q);
        xa = '0;
        xb = '0;
        xe = ROW_W'(esc_q);
        for (int j = 0; j < N; j++) begin
            row_full[j] = '0;
            if (j < nn) begin
                xa = ROW_W'(elem(a_q, ri, j));
                xb = ROW_W'(elem(b_q, ri, j));
                case (op_q)
                    OP_SOMA:   row_full[j] = xa + xb;
                    OP_SUB:    row_full[j] = xa - xb;
                    OP_OPOSTA: row_full[j] = -xa;
                    OP_ESC:    row_full[j] = xe * xa;
                    OP_TRANSP: row_full[j] = ROW_W'(elem(a_q, j, ri));
                    default:   row_full[j] = '0;
                endcase
            end
        end

        acc = '0;
        pa  = '0;
        pb  = '0;
        for (int k = 0; k < N; k++) begin
            if (k < nn) begin
                pa  = ACC_W'(elem(a_q, ri, k));
                pb  = ACC_W'(elem(b_q, k, ci));
                acc = acc + pa * pb;
            end
        end

        buf_d    = buf_q;
        ovf_step = 1'b0;
        if (op_q == OP_MUL) begin
            buf_d[elem_idx(ri, ci, N)*DATA_W +: DATA_W] = mac_res;
            ovf_step = mac_ovf;
        end else begin
            for (int j = 0; j < N; j++) begin
                buf_d[elem_idx(ri, j, N)*DATA_W +: DATA_W] = (j < nn) ? row_res[j] : '0;
                if (j < nn) ovf_step = ovf_step | row_ovf[j];
            end
        end

        last = (r_q == n_q - SIZE_W'(1)) &&
               ((op_q != OP_MUL) || (c_q == n_q - SIZE_W'(1)));
        start_ok = op_valid(opcode) && (tamanho != '0) && (tamanho <= SIZE_W'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            esc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            buf_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && start_ok) begin
                        op_q    <= opcode;
                        n_q     <= tamanho;
                        esc_q   <= data_escalar;
                        a_q     <= matriz_a;
                        b_q     <= matriz_b;
                        r_q     <= '0;
                        c_q     <= '0;
                        buf_q   <= '0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (start) begin
                        res_q   <= '0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    buf_q <= buf_d;
                    ovf_q <= ovf_q | ovf_step;
                    if (last) begin
                        res_q   <= buf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (op_q == OP_MUL && c_q != n_q - SIZE_W'(1)) begin
                        c_q <= c_q + SIZE_W'(1);
                    end else begin
                        c_q <= '0;
                        r_q <= r_q + SIZE_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign matriz_resultante = res_q;
    assign done              = done_q;
    assign busy              = busy_q;
    assign overflow          = ovf_q;
    assign err               = err_q;

endmodule

// File: tb/tb_matriz_alu_seq.sv
// Directed self-checking bench for matriz_alu_seq (N=5, DATA_W=8), saturating and wrapping builds.
module tb_matriz_alu_seq;

    localparam int MW = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    opcode = '0;
    logic [2:0]    tamanho = '0;
    logic [7:0]    esc = '0;
    logic [MW-1:0] ma = '0, mb = '0, ex = '0;
    logic [MW-1:0] res0, res1;
    logic          done0, busy0, ovf0, err0;
    logic          done1, busy1, ovf1, err1;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;
    int lat;
    int bad;

    always #5 clk = ~clk;

    matriz_alu_seq #(.DATA_W(8), .N(5), .SATURATE(1)) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .opcode (opcode), .tamanho (tamanho),
        .data_escalar (esc), .matriz_a (ma), .matriz_b (mb), .matriz_resultante (res0),
        .done (done0), .busy (busy0), .overflow (ovf0), .err (err0)
    );

    matriz_alu_seq #(.DATA_W(8), .N(5), .SATURATE(0)) u_dut_wrap (
        .clk (clk), .rst_n (rst_n), .start (start), .opcode (opcode), .tamanho (tamanho),
        .data_escalar (esc), .matriz_a (ma), .matriz_b (mb), .matriz_resultante (res1),
        .done (done1), .busy (busy1), .overflow (ovf1), .err (err1)
    );

    task automatic check_eq(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic put(inout logic [MW-1:0] m, input int i, input int j, input logic [7:0] v);
        m[(i*5+j)*8 +: 8] = v;
    endtask

    // Drive a request before a rising edge and stop just after the capturing edge.
    task automatic start_op(input logic [3:0] op, input logic [2:0] n, input logic [7:0] s);
        @(negedge clk);
        opcode  = op;
        tamanho = n;
        esc     = s;
        start   = 1'b1;
        @(posedge clk);
        #1;
        busy_cnt = busy0 ? 1 : 0;
    endtask

    // Returns the number of rising edges after capture until done, or -1 on timeout.
    task automatic wait_done(output int l);
        l = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (busy0) busy_cnt++;
            if (done0) begin
                l = e;
                break;
            end
        end
    endtask

    task automatic end_op();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("done_clear", done0, 1'b0);
    endtask

    initial begin
        #12;
        check_eq("rst_res", res0, '0);
        check_eq("rst_flags", {done0, busy0, ovf0, err0}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Add, saturating: 150 -> 127 inside 3x3, zero outside.
        ma = '0; mb = '0; ex = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                put(ma, i, j, 8'd100);
                put(mb, i, j, 8'd50);
                if (i < 3 && j < 3) put(ex, i, j, 8'h7f);
            end
        start_op(4'b0011, 3'd3, 8'd0);
        check_eq("add_busy", busy0, 1'b1);
        wait_done(lat);
        check_eq("add_lat", lat, 3);
        check_eq("add_res", res0, ex);
        check_eq("add_ovf", ovf0, 1'b1);
        end_op();

        // Multiply 2x2 with start dropped and operands scrambled during RUN.
        ma = '0; mb = '0; ex = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                put(ma, i, j, 8'd9);
                put(mb, i, j, 8'd9);
            end
        put(ma, 0, 0, 8'd1); put(ma, 0, 1, 8'd2); put(ma, 1, 0, 8'd3); put(ma, 1, 1, 8'd4);
        put(mb, 0, 0, 8'd5); put(mb, 0, 1, 8'd6); put(mb, 1, 0, 8'd7); put(mb, 1, 1, 8'd8);
        put(ex, 0, 0, 8'd19); put(ex, 0, 1, 8'd22); put(ex, 1, 0, 8'd43); put(ex, 1, 1, 8'd50);
        start_op(4'b0101, 3'd2, 8'd0);
        start = 1'b0;
        ma = {MW{1'b1}};
        wait_done(lat);
        check_eq("mul_lat", lat, 4);
        check_eq("mul_busy_cycles", busy_cnt, 4);
        check_eq("mul_res", res0, ex);
        check_eq("mul_ovf_err", {ovf0, err0}, 2'b00);
        @(posedge clk);
        #1;
        check_eq("mul_done_pulse", done0, 1'b0);

        // Scalar -2 times A on 2x2: -6 and saturated +140.
        ma = '0; ex = '0;
        put(ma, 0, 0, 8'd3); put(ma, 0, 1, 8'hba); put(ma, 3, 3, 8'd1);
        put(ex, 0, 0, 8'hfa); put(ex, 0, 1, 8'h7f);
        start_op(4'b1000, 3'd2, 8'hfe);
        wait_done(lat);
        check_eq("esc_lat", lat, 2);
        check_eq("esc_res", res0, ex);
        check_eq("esc_ovf", ovf0, 1'b1);
        end_op();

        // Negate -128 in both arithmetic modes.
        ma = '0; mb = '0;
        put(ma, 0, 0, 8'h80); put(ma, 0, 1, 8'd5);
        start_op(4'b0111, 3'd1, 8'd0);
        wait_done(lat);
        check_eq("neg_lat", lat, 1);
        ex = '0; put(ex, 0, 0, 8'h7f);
        check_eq("neg_sat_res", res0, ex);
        check_eq("neg_sat_ovf", ovf0, 1'b1);
        ex = '0; put(ex, 0, 0, 8'h80);
        check_eq("neg_wrap_res", res1, ex);
        check_eq("neg_wrap_ovf", ovf1, 1'b1);
        end_op();

        // Transpose 5x5, then hold start high in DONE.
        ma = '0; ex = '0;
        put(ma, 0, 1, 8'd7); put(ma, 4, 2, 8'hfd); put(ma, 3, 3, 8'd5);
        put(ex, 1, 0, 8'd7); put(ex, 2, 4, 8'hfd); put(ex, 3, 3, 8'd5);
        start_op(4'b0110, 3'd5, 8'd0);
        wait_done(lat);
        check_eq("tr_lat", lat, 5);
        check_eq("tr_res", res0, ex);
        check_eq("tr_ovf", ovf0, 1'b0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!done0 || busy0 || res0 !== ex) bad++;
        end
        check_eq("tr_hold", bad, 0);
        end_op();

        // Invalid opcode and sizes: immediate done with err and zero result.
        start_op(4'b1111, 3'd2, 8'd0);
        check_eq("bad_op", {done0, err0, busy0, ovf0}, 4'b1100);
        check_eq("bad_op_res", res0, '0);
        end_op();
        start_op(4'b0011, 3'd0, 8'd0);
        check_eq("bad_n0", {done0, err0, busy0, ovf0}, 4'b1100);
        end_op();
        start_op(4'b0011, 3'd6, 8'd0);
        check_eq("bad_n6", {done0, err0, busy0, ovf0}, 4'b1100);
        check_eq("bad_n6_res", res0, '0);
        end_op();

        // Load a nonzero result, then reset mid 5x5 multiply and restart.
        ma = '0; mb = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) put(ma, i, j, 8'd100);
        start_op(4'b0011, 3'd1, 8'd0);
        wait_done(lat);
        end_op();
        ma = '0; ex = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                put(ma, i, j, 8'd1);
                put(mb, i, j, 8'(j));
                put(ex, i, j, 8'(5 * j));
            end
        start_op(4'b0101, 3'd5, 8'd0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_res", res0, '0);
        check_eq("arst_flags", {done0, busy0, ovf0, err0}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstart_busy", busy0, 1'b1);
        wait_done(lat);
        check_eq("rstart_lat", lat, 25);
        check_eq("rstart_res", res0, ex);
        check_eq("rstart_ovf", ovf0, 1'b0);
        end_op();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matriz_alu_seq.md
Name: matriz_alu_seq

Overview:
- Parametrised, sequential successor to the coprocessor's matrix ALU.
- Operates on square signed matrices of configurable element width and maximum dimension, with a runtime-selectable active size.
- Processes one row per cycle for element-wise ops and one element per cycle for multiplication, with selectable saturating or wrapping arithmetic.
- Sits between the coprocessor's instruction decoder and the result/writeback path, using the same start/done level handshake.

Parameters:
- DATA_W, 8: element width in bits, signed two's complement.
- N, 5: maximum matrix dimension. Buses are N*N*DATA_W bits wide.
- SATURATE, 1: 1 clamps overflowing results to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; 0 wraps modulo 2^DATA_W.
- SIZE_W, $clog2(N+1): width of the size input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  operation request, level held by the requester.
- opcode  input  4  operation select.
- tamanho  input  SIZE_W  active dimension n of the operation.
- data_escalar  input  DATA_W  signed scalar.
- matriz_a  input  N*N*DATA_W  operand A.
- matriz_b  input  N*N*DATA_W  operand B.
- matriz_resultante  output  N*N*DATA_W  registered result.
- done  output  1  result valid; held until start is low.
- busy  output  1  high while in RUN.
- overflow  output  1  at least one element saturated or wrapped.
- err  output  1  invalid opcode or invalid size.

Behaviour:
- Element layout: element (i,j), with i as the row, occupies bits [(i*N+j)*DATA_W +: DATA_W].
- Reset (asynchronous, rst_n low):
  - state goes to IDLE.
  - matriz_resultante, done, busy, overflow, err and all counters go to 0.
- Opcodes:
  - 0011: A+B.
  - 0100: A-B.
  - 0101: A*B (matrix product).
  - 0110: transpose of A.
  - 0111: -A.
  - 1000: data_escalar*A.
  - Any other value is invalid.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE, start=1 with a valid opcode and 1<=tamanho<=N:
    - latch opcode, tamanho, data_escalar, matriz_a and matriz_b;
    - clear the internal result buffer, overflow and err;
    - set busy=1 and go to RUN.
  - IDLE, start=1 with an invalid opcode or an invalid tamanho (0 or >N):
    - go directly to DONE with err=1, matriz_resultante=0, overflow=0.
  - RUN, element-wise ops and transpose:
    - row counter r runs 0..n-1, writing row r of the n x n region per cycle.
    - Latency L = n cycles.
  - RUN, multiply:
    - counters (i,j) run row-major, computing one element per cycle as sum over k<n of A[i][k]*B[k][j].
    - The accumulator is 2*DATA_W+$clog2(N) bits, reduced to DATA_W by saturation or wrap only at the end.
    - Latency L = n*n cycles.
  - RUN, final cycle: matriz_resultante is loaded from the buffer, done=1, busy=0, go to DONE.
    - done rises exactly L rising edges after the edge that captured start.
  - DONE: hold done, matriz_resultante, overflow and err stable; when start=0, clear done and go to IDLE.
- Result contents:
  - Elements outside the n x n region are 0.
  - Inputs outside that region are ignored.
- Width and overflow rules:
  - Each element result is computed at full precision, then reduced per SATURATE.
  - overflow is the OR over all reduced elements of (full result != reduced result).
  - -(-2^(DATA_W-1)) overflows.
  - Transpose never overflows.
- Boundary conditions:
  - start dropped during RUN: the operation completes on the latched operands. DONE then sees start=0, so done is a one-cycle pulse.
  - Operand changes during RUN are ignored.
  - start held high in DONE: no new operation starts; a new operation requires start low for at least one cycle.
  - rst_n low mid-RUN aborts immediately. After release, start=1 in IDLE starts a fresh operation.
  - tamanho=1: L=1 for all valid ops.

Decomposition:
- Package matriz_alu_pkg holds:
  - opcode localparams (OP_SOMA, OP_SUB, OP_MUL, OP_TRANSP, OP_OPOSTA, OP_ESC);
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - an element index helper function.
- Sub-module mat_elem_sat, parametrised by input width IN_W, DATA_W and SATURATE:
  - input: a signed full-precision value;
  - outputs: the DATA_W result and an overflow bit.
  - Instantiate it N times for the row path and once for the MAC path.

Test Plan:
- Add, N=5, SATURATE=1, n=3, A and B all 100/50 -> 3x3 region 127, remainder 0, overflow=1, done 3 edges after capture.
- Multiply, n=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> [[19,22],[43,50]], overflow=0, done after 4 edges, busy high for 4 cycles.
- Opposite, A[0][0]=-128, n=1:
  - SATURATE=1 -> 127, overflow=1;
  - SATURATE=0 -> -128, overflow=1.
- Transpose, n=5, A[0][1]=7, A[4][2]=-3 -> R[1][0]=7, R[2][4]=-3, overflow=0. Then hold start high 10 cycles -> done stays 1 and no restart.
- Invalid cases:
  - opcode=1111 -> done=1 on the edge after capture, err=1, result 0.
  - tamanho=0, and separately tamanho=6 -> same response.
- rst_n low at cycle 10 of a 5x5 multiply -> all outputs 0 asynchronously. Release with start=1 -> a new multiply completes in 25 cycles with the correct result.
